// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states and lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeBad  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StWrite,
        StResp
    } state_e;

    localparam int unsigned LaneBits     = 8;
    localparam int unsigned LanesPerWord = 4;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SizeByte: size_bytes = 3'd1;
            SizeHalf: size_bytes = 3'd2;
            SizeWord: size_bytes = 3'd4;
            default:  size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts/extends load data and merges sub-word store data.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    assign w_shamt   = {i_lane, 3'b000};
    assign w_shifted = i_word >> w_shamt;

    always_comb begin
        o_load   = i_word;
        o_merged = i_word;
        w_mask   = '0;
        w_ins    = '0;
        case (i_size)
            SizeByte: begin
                o_load   = i_unsigned ? {24'b0, w_shifted[LaneBits-1:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
                w_mask   = 32'h0000_00ff << w_shamt;
                w_ins    = {24'b0, i_wdata[7:0]} << w_shamt;
                o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
            end
            SizeHalf: begin
                o_load   = i_unsigned ? {16'b0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
                w_mask   = 32'h0000_ffff << w_shamt;
                w_ins    = {16'b0, i_wdata[15:0]} << w_shamt;
                o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
            end
            SizeWord: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
            default: begin
                o_load   = i_word;
                o_merged = i_word;
            end
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write for sub-word stores over a word-wide memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_mem_ce;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [32:0] w_end;
    logic        w_err;
    logic [31:0] w_addr;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Range check uses the address as issued, before any forced alignment.
    assign w_end = {1'b0, req_addr} + {30'b0, size_bytes(req_size)};

    always_comb begin
        w_addr = req_addr;
        w_err  = (req_size == SizeBad) || (w_end > 33'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == SizeHalf && req_addr[0]) ||
            (req_size == SizeWord && req_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
`else
        if (req_size == SizeHalf) begin
            w_addr[0] = 1'b0;
        end else if (req_size == SizeWord) begin
            w_addr[1:0] = 2'b00;
        end
`endif
    end

    lsu_lane u_lane (
        .i_word     (mem_rdata),
        .i_lane     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            // Pulses and memory strobes default low; each state re-asserts what it needs.
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= w_addr;
                        r_wdata    <= req_wdata;
                        if (w_err) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_mem_ce   <= 1'b1;
                            r_mem_addr <= {w_addr[31:2], 2'b00};
                            if (!req_we) begin
                                r_state <= StLoad;
                            end else if (req_size == SizeWord) begin
                                r_state     <= StWrite;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end else begin
                                r_state <= StRmwRd;
                            end
                        end
                    end
                end
                StLoad, StRmwRd: begin
                    if (!r_we) begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end else begin
                        r_state     <= StWrite;
                        r_mem_ce    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_addr[31:2], 2'b00};
                        r_mem_wdata <= w_merged;
                    end
                end
                StWrite: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_ce     = r_mem_ce;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed self-checking bench for lsu_rmw with a behavioural word memory.
// Expectations for the misaligned half load follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [256];
    bit          seeded = 1'b0;
    int          n_wr = 0;
    int          n_ce = 0;
    int          n_resp = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_rd_addr = '0;

    always #5 clk = ~clk;

    lsu_rmw #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = (mem_ce && !mem_we && mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]   <= 32'h8899_AABB;
            mem[8]   <= 32'h1122_3344;
            mem[255] <= 32'h7F00_0000;
            seeded   <= 1'b1;
        end else begin
            if (mem_ce) begin
                n_ce <= n_ce + 1;
                if (mem_we) begin
                    n_wr         <= n_wr + 1;
                    last_wr_addr <= mem_addr;
                    last_wr_data <= mem_wdata;
                    if (mem_addr < 32'd1024) mem[mem_addr[9:2]] <= mem_wdata;
                end else begin
                    last_rd_addr <= mem_addr;
                end
            end
            if (resp_valid) n_resp <= n_resp + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response; lat=0 means none arrived.
    task automatic run(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat   = 0;
        rdata = 'x;
        err   = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          w0, c0, r0, k;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp [4];
        logic [31:0] got [$];

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_ce", {31'b0, mem_ce}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, e);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_data", rd, 32'hFFFF_FF88);
        chk("lb_rdaddr", last_rd_addr, 32'h10);
        run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, e);
        chk("lbu_data", rd, 32'h0000_0088);
        run(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, e);
        chk("lh_data", rd, 32'hFFFF_8899);
        run(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, e);
        chk("lhu_data", rd, 32'h0000_AABB);
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("lw_data", rd, 32'h8899_AABB);
        chk("lw_err", {31'b0, e}, 32'd0);

        w0 = n_wr;
        run(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, lat, rd, e);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_nwr", 32'(n_wr - w0), 32'd1);
        chk("sh_wraddr", last_wr_addr, 32'h20);
        chk("sh_wrdata", last_wr_data, 32'hBEEF_3344);
        chk("sh_rdata", rd, 32'h0);
        w0 = n_wr;
        run(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF5A, lat, rd, e);
        chk("sb_nwr", 32'(n_wr - w0), 32'd1);
        chk("sb_wrdata", last_wr_data, 32'hBEEF_5A44);

        w0 = n_wr; c0 = n_ce;
        run(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, lat, rd, e);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_nwr", 32'(n_wr - w0), 32'd1);
        chk("sw_nce", 32'(n_ce - c0), 32'd1);
        chk("sw_wraddr", last_wr_addr, 32'h0C);
        chk("sw_wrdata", last_wr_data, 32'hDEAD_BEEF);
        chk("sw_err", {31'b0, e}, 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rd, e);
        chk("sw_readback", rd, 32'hDEAD_BEEF);

        c0 = n_ce;
        run(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, lat, rd, e);
        chk("oob_lat", 32'(lat), 32'd1);
        chk("oob_err", {31'b0, e}, 32'd1);
        chk("oob_rdata", rd, 32'h0);
        chk("oob_nce", 32'(n_ce - c0), 32'd0);
        c0 = n_ce;
        run(1'b1, 2'b11, 1'b0, 32'h0, 32'h1234_5678, lat, rd, e);
        chk("badsize_err", {31'b0, e}, 32'd1);
        chk("badsize_nce", 32'(n_ce - c0), 32'd0);
        run(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, lat, rd, e);
        chk("lb_top_err", {31'b0, e}, 32'd0);
        chk("lb_top_data", rd, 32'h0000_007F);
        run(1'b0, 2'b01, 1'b0, 32'h3FF, 32'h0, lat, rd, e);
        chk("lh_top_err", {31'b0, e}, 32'd1);

        c0 = n_ce;
        run(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, rd, e);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_err", {31'b0, e}, 32'd1);
        chk("lh_mis_nce", 32'(n_ce - c0), 32'd0);
`else
        chk("lh_mis_err", {31'b0, e}, 32'd0);
        chk("lh_mis_rdaddr", last_rd_addr, 32'h20);
        chk("lh_mis_data", rd, 32'h0000_5A44);
`endif

        b2b_addr[0] = 32'h10;  b2b_exp[0] = 32'h8899_AABB;
        b2b_addr[1] = 32'h20;  b2b_exp[1] = 32'hBEEF_5A44;
        b2b_addr[2] = 32'h0C;  b2b_exp[2] = 32'hDEAD_BEEF;
        b2b_addr[3] = 32'h3FC; b2b_exp[3] = 32'h7F00_0000;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("b2b_ready", {31'b0, req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            if (resp_valid) got.push_back(resp_rdata);
            if (req_ready && k < 4) begin
                req_valid = 1'b1;
                req_addr  = b2b_addr[k];
                k++;
            end
            if (c == 11) req_valid = 1'b0;
        end
        chk("b2b_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_data", (i < got.size()) ? got[i] : 32'hxxxx_xxxx, b2b_exp[i]);
        end

        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h24; req_wdata = 32'h0000_1234; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_write", {31'b0, mem_we}, 32'd1);
        w0 = n_wr; r0 = n_resp;
        rst_n = 1'b0;
        #1;
        chk("abort_we_low", {31'b0, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_nwr", 32'(n_wr - w0), 32'd0);
        chk("abort_nresp", 32'(n_resp - r0), 32'd0);
        chk("abort_mem", mem[9], 32'h0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning data memory size in bytes; addresses at or above it are out of range.
REQ-002 SHALL have ports, in order:
  clk  in  1  clock; all state updates on posedge.
  rst_n  in  1  reset; asynchronous assert, active-low.
  req_valid  in  1  core request present.
  req_ready  out  1  block can accept a request.
  req_we  in  1  1=store, 0=load.
  req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal.
  req_unsigned  in  1  zero-extend load result (lbu/lhu).
  req_addr  in  32  byte address.
  req_wdata  in  32  store data, right-aligned.
  resp_valid  out  1  one-cycle completion pulse.
  resp_rdata  out  32  load result, extended; 0 for stores and errors.
  resp_err  out  1  request rejected, no memory write done.
  mem_ce  out  1  data memory chip enable.
  mem_we  out  1  data memory write enable.
  mem_addr  out  32  word-aligned memory address.
  mem_wdata  out  32  full-word write data.
  mem_rdata  in  32  memory read data; combinational from mem_addr when mem_ce=1 and mem_we=0.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-004 SHALL assert req_ready only in IDLE; accept on the edge with req_valid && req_ready, latching all req_* fields.
REQ-005 SHALL flag an error when req_size=11, when addr+size_bytes > MEM_BYTES, or on misalignment per REQ-014; IDLE -> RESP directly on error.
REQ-006 SHALL transition IDLE -> LOAD (load), IDLE -> WRITE (word store), and IDLE -> RMW_RD (byte/half store).
REQ-007 SHALL drive mem_ce=1, mem_we=0, mem_addr={addr[31:2],2'b00} in LOAD and RMW_RD, capturing mem_rdata at the end of that cycle.
REQ-008 SHALL, in LOAD, select the lane at addr[1:0] and sign-extend from bit 7/15 unless req_unsigned=1, then move to RESP.
REQ-009 SHALL, in RMW_RD, merge req_wdata[7:0] or [15:0] into the captured word at lane addr[1:0], leaving the other bytes unchanged, then move to WRITE.
REQ-010 SHALL drive mem_ce=1, mem_we=1, mem_addr aligned, mem_wdata = merged or full word for exactly one cycle in WRITE, then move to RESP.
REQ-011 SHALL assert resp_valid for exactly one cycle in RESP, with resp_rdata/resp_err valid, then return to IDLE; no backpressure on the response.
REQ-012 SHALL give latency from acceptance edge to resp_valid of: error 1 cycle, load or word store 2 cycles, sub-word store 3 cycles.
REQ-013 SHALL hold mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0 in IDLE and RESP; resp_valid=0 outside RESP.

Reset
REQ-015 SHALL, while rst_n=0, force state IDLE, clear all latched fields and drive every output to 0 except req_ready, which is 1 after reset release.
REQ-016 SHALL abort a reset mid-operation with no write issued, including in WRITE, and no resp_valid.

Configuration
REQ-014 SHALL, with LSU_MISALIGN_TRAP_EN defined, flag half with addr[0]=1 and word with addr[1:0]!=0 as errors; without it, SHALL force those low bits to 0 and proceed.

Structure
REQ-017 SHALL take size encodings, the FSM state enum and lane helper constants from shared package lsu_pkg.
REQ-018 SHALL place lane extract/extend and merge logic in combinational sub-module lsu_lane.

Verification
REQ-019 Load: mem word 0x8899AABB at 0x10, lb addr 0x13 -> resp_rdata 0xFFFFFF88 two cycles after acceptance; lbu -> 0x00000088.
REQ-020 Sub-word store: word 0x11223344 at 0x20, sh 0xBEEF to 0x22 -> one write 0xBEEF3344 to 0x20, resp_valid three cycles after acceptance.
REQ-021 Word store: sw 0xDEADBEEF to 0x0C -> one write cycle, mem_wdata 0xDEADBEEF, mem_addr 0x0C, resp_err=0.
REQ-022 Errors: lw 0x3FE (MEM_BYTES=1024) -> resp_err=1, no mem_ce; lh 0x21 -> error with the macro, reads 0x20 without it.
REQ-023 Reset: deassert rst_n during WRITE -> no mem_we pulse, no resp_valid, req_ready=1 after release.
REQ-024 Back-to-back: req_valid held high for 4 loads -> req_ready low except in IDLE, 4 resp_valid pulses in order.
